// File: rtl/seq_pkg.sv
// Shared types and default sizing for the sequence record/replay counter.
package seq_pkg;

  localparam int unsigned SEQ_W     = 3;
  localparam int unsigned SEQ_CW    = 3;
  localparam int unsigned SEQ_DEPTH = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_record_counter_if.sv
// Controller <-> step counter bundle; master is the controller, slave the counter.
interface seq_record_counter_if #(
  parameter int unsigned W  = seq_pkg::SEQ_W,
  parameter int unsigned CW = seq_pkg::SEQ_CW
);
  logic          clear;
  logic [W-1:0]  in;
  logic          step_en;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic          q_valid;
  logic          seq_done;
  logic          recording;

  modport master (
    output clear, in, step_en,
    input  count, q, q_valid, seq_done, recording
  );

  modport slave (
    input  clear, in, step_en,
    output count, q, q_valid, seq_done, recording
  );
endinterface

// File: rtl/seq_store.sv
// DEPTH x W register file: one write port, one combinational read port, async-reset to zero.
module seq_store #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 6,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/seq_record_counter.sv
// Step counter that records DEPTH controller codes and replays them on q.
// Build option: SEQ_LOOP_EN makes replay wrap and repeat until clear instead of stopping in DONE.
module seq_record_counter
  import seq_pkg::*;
#(
  parameter int unsigned W     = SEQ_W,
  parameter int unsigned CW    = SEQ_CW,
  parameter int unsigned DEPTH = SEQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_record_counter_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH > (1 << CW)) begin : g_depth_check
    $error("seq_record_counter: DEPTH does not fit in CW-bit count");
  end

  seq_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  q_q, q_d;
  logic          q_valid_q, q_valid_d;
  logic          seq_done_q, seq_done_d;
  logic          recording_q, recording_d;
  logic          we_c;
  logic          last_c;
  logic [W-1:0]  rdata;

  seq_store #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_c),
    .waddr (AW'(count_q)),
    .wdata (bus.in),
    .raddr (AW'(count_q)),
    .rdata (rdata)
  );

  assign last_c = (count_q == CW'(DEPTH - 1));

  // Next-state, index and output-register logic; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    seq_done_d = 1'b0;
    we_c       = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RECORD;
          count_d = '0;
        end
        RECORD: if (bus.step_en) begin
          we_c = 1'b1;
          if (last_c) begin
            count_d = '0;
            state_d = PLAY;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        PLAY: if (bus.step_en) begin
          q_d       = rdata;
          q_valid_d = 1'b1;
          if (last_c) begin
            seq_done_d = 1'b1;
`ifdef SEQ_LOOP_EN
            count_d = '0;
`else
            state_d = DONE;
`endif
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
    recording_d = (state_d == RECORD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      seq_done_q  <= 1'b0;
      recording_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      seq_done_q  <= seq_done_d;
      recording_q <= recording_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.q         = q_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.recording = recording_q;

endmodule

// File: tb/tb_seq_record_counter.sv
// Directed table-driven bench for seq_record_counter; honours SEQ_LOOP_EN like the RTL.
module tb_seq_record_counter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_record_counter_if bus ();

  seq_record_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       se;
    logic [2:0] code;
    logic [2:0] cnt;
    logic [2:0] q;
    logic       qv;
    logic       done;
    logic       rec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] cnt, input logic [2:0] q,
                            input logic qv, input logic done, input logic rec);
    chk({tag, ".count"},     8'(bus.count),     8'(cnt));
    chk({tag, ".q"},         8'(bus.q),         8'(q));
    chk({tag, ".q_valid"},   8'(bus.q_valid),   8'(qv));
    chk({tag, ".seq_done"},  8'(bus.seq_done),  8'(done));
    chk({tag, ".recording"}, 8'(bus.recording), 8'(rec));
  endtask

  // Drive on the falling edge, sample 1 ns after the next rising edge.
  task automatic cyc(input string tag, input logic clr, input logic se, input logic [2:0] code,
                     input logic [2:0] cnt, input logic [2:0] q, input logic qv,
                     input logic done, input logic rec);
    @(negedge clk);
    bus.clear   = clr;
    bus.step_en = se;
    bus.in      = code;
    @(posedge clk);
    #1;
    check_outs(tag, cnt, q, qv, done, rec);
  endtask

  initial begin
    logic [2:0] last_cnt;
    logic [2:0] hold_q;
    logic [2:0] rec1 [6];
    logic [2:0] rec2 [6];
    logic [2:0] fresh [6];
    logic [2:0] mem3;

    n_checks = 0;
    n_fail   = 0;
    rec1  = '{3'd5, 3'd5, 3'd2, 3'd2, 3'd6, 3'd6};
    rec2  = '{3'd3, 3'd4, 3'd1, 3'd7, 3'd0, 3'd2};
    fresh = '{3'd7, 3'd1, 3'd0, 3'd3, 3'd4, 3'd2};

`ifdef SEQ_LOOP_EN
    last_cnt = 3'd0;
`else
    last_cnt = 3'd5;
`endif

    // Test 1: record 5,5,2,2,6,6.
    vecs.push_back('{1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'b0, 1'b1, rec1[i], 3'((i + 1) % 6), 3'd0, 1'b0, 1'b0, (i != 5)});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    // Test 2: replay; seq_done with the final q=6.
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 1'b1, 3'd7, 3'(i + 1), rec1[i], 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd7, last_cnt, 3'd6, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'd7, last_cnt, 3'd6, 1'b0, 1'b0, 1'b0});
    // Test 3: seventh play step.
`ifdef SEQ_LOOP_EN
    vecs.push_back('{1'b0, 1'b1, 3'd0, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0});
    hold_q = 3'd5;
`else
    vecs.push_back('{1'b0, 1'b1, 3'd0, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0});
    hold_q = 3'd6;
`endif
    // Test 4: clear, partial re-record, then clear together with step_en at count 3.
    vecs.push_back('{1'b1, 1'b0, 3'd0, 3'd0, hold_q, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 3'd0, hold_q, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b0, 1'b1, 3'd1, 3'(i + 1), hold_q, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 3'd7, 3'd0, hold_q, 1'b0, 1'b0, 1'b0});

    rst_n       = 1'b0;
    bus.clear   = 1'b0;
    bus.step_en = 1'b0;
    bus.in      = 3'd0;
    #2;
    check_outs("reset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      cyc($sformatf("vec%0d", i), vecs[i].clr, vecs[i].se, vecs[i].code,
          vecs[i].cnt, vecs[i].q, vecs[i].qv, vecs[i].done, vecs[i].rec);

    mem3 = dut.u_store.mem_q[3];
    chk("clear_no_write.store3", 8'(mem3), 8'd2);

    // Test 5: re-record, replay to count 4, then pulse reset mid-PLAY.
    cyc("rec2.start", 1'b0, 1'b0, 3'd0, 3'd0, hold_q, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      cyc($sformatf("rec2.%0d", i), 1'b0, 1'b1, rec2[i], 3'((i + 1) % 6), hold_q,
          1'b0, 1'b0, (i != 5));
    for (int i = 0; i < 4; i++)
      cyc($sformatf("play2.%0d", i), 1'b0, 1'b1, 3'd0, 3'(i + 1), rec2[i], 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    bus.step_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    check_outs("midreset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    mem3 = dut.u_store.mem_q[0];
    chk("midreset.store0", 8'(mem3), 8'd0);

    cyc("rec3.start", 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      cyc($sformatf("rec3.%0d", i), 1'b0, 1'b1, fresh[i], 3'((i + 1) % 6), 3'd0,
          1'b0, 1'b0, (i != 5));
    for (int i = 0; i < 6; i++)
      cyc($sformatf("play3.%0d", i), 1'b0, 1'b1, 3'd0, (i == 5) ? last_cnt : 3'(i + 1),
          fresh[i], 1'b1, (i == 5), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
